// File: rtl/integration_pkg.sv
// Shared AHB definitions for the arbiter slice.
//   htrans_t / hburst_t : AHB transfer and burst encodings
//   MASTER_NUMBER       : largest supported master count (sets index width)
//   burst_len()         : beats-1 for a burst type (0 for SINGLE/INCR)
package integration_pkg;

  localparam int MASTER_NUMBER = 16;
  localparam int MIDX_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  function automatic logic [MIDX_W-1:0] burst_len(input hburst_t b);
    case (b)
      WRAP4,  INCR4:  burst_len = 4'd3;
      WRAP8,  INCR8:  burst_len = 4'd7;
      WRAP16, INCR16: burst_len = 4'd15;
      default:        burst_len = 4'd0;  // SINGLE, undefined-length INCR
    endcase
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner selection.
//   i_req   : request vector, one bit per master
//   i_start : round-robin scan start index
//   i_mode  : 0 = fixed priority (index 0 highest), 1 = round-robin from i_start
//   o_idx   : winning master index (0 when nobody requests)
//   o_valid : at least one request present
module arb_priority_sel
  import integration_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      i_req,
  input  logic [MIDX_W-1:0] i_start,
  input  logic              i_mode,
  output logic [MIDX_W-1:0] o_idx,
  output logic              o_valid
);

  always_comb begin : p_sel
    int j;
    j       = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    if (!i_mode) begin
      // Scan downward so the lowest asserted index is the last one written.
      for (int i = N-1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_idx   = MIDX_W'(i);
          o_valid = 1'b1;
        end
      end
    end else begin
      // Same trick on the rotated order: offset 0 from i_start wins.
      for (int k = N-1; k >= 0; k--) begin
        j = (int'(i_start) + k) % N;
        if (i_req[j]) begin
          o_idx   = MIDX_W'(j);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_core.sv
// AHB bus-ownership arbiter. Re-arbitrates only at legal handover points:
// hready high, burst counter at zero, and current owner not holding a lock.
//   hclk, hreset : clock, synchronous active-high reset
//   hbusreq      : per-master bus request
//   hlock        : per-master locked-access request
//   htrans       : transfer type of the current owner
//   hburst       : burst type of the current owner
//   hready       : address-phase advance
//   hgrant       : one-hot grant (registered, never zero)
//   hmaster      : address-phase owner index (registered)
//   hmastlock    : current transfer is locked (registered)
module ahb_arbiter_core
  import integration_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = NUM_MASTERS-1,
  parameter int ARB_MODE       = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [MIDX_W-1:0] DEF_IDX  = MIDX_W'(DEFAULT_MASTER);
  localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(NUM_MASTERS-1);
  localparam logic              RR_MODE  = (ARB_MODE != 0);

  logic [NUM_MASTERS-1:0]   r_hgrant;
  logic [MIDX_W-1:0]        r_owner;
  logic [MIDX_W-1:0]        r_hmaster;
  logic                     r_hmastlock;
  logic [MIDX_W-1:0]        r_burst_cnt;
  logic [MIDX_W-1:0]        r_rr_ptr;

  logic [MASTER_NUMBER-1:0] w_lock16;
  logic [MASTER_NUMBER-1:0] w_req16;
  logic                     w_own_locked;
  logic                     w_arb_en;
  logic [MIDX_W-1:0]        w_sel_idx;
  logic                     w_sel_vld;
  logic [MIDX_W-1:0]        w_win;
  logic [MIDX_W-1:0]        w_ptr_nxt;
  logic [MIDX_W-1:0]        w_cnt_nxt;

  arb_priority_sel #(.N(NUM_MASTERS)) u_sel (
    .i_req   (hbusreq),
    .i_start (r_rr_ptr),
    .i_mode  (RR_MODE),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_vld)
  );

  // Widen to the full index range so r_owner can index without truncation.
  always_comb begin
    w_lock16 = '0;
    w_req16  = '0;
    w_lock16[NUM_MASTERS-1:0] = hlock;
    w_req16[NUM_MASTERS-1:0]  = hbusreq;
  end

  assign w_own_locked = w_lock16[r_owner] & w_req16[r_owner];
  assign w_arb_en     = hready & (r_burst_cnt == '0) & ~w_own_locked;
  assign w_win        = w_sel_vld ? w_sel_idx : DEF_IDX;
  assign w_ptr_nxt    = (w_win == LAST_IDX) ? '0 : w_win + 4'd1;

  // Remaining-beats counter; only moves on an accepted address phase.
  always_comb begin
    w_cnt_nxt = r_burst_cnt;
    if (hready) begin
      case (htrans_t'(htrans))
        NONSEQ:  w_cnt_nxt = burst_len(hburst_t'(hburst));
        SEQ:     if (r_burst_cnt != '0) w_cnt_nxt = r_burst_cnt - 4'd1;
        IDLE:    w_cnt_nxt = '0;  // early termination frees the bus
        default: w_cnt_nxt = r_burst_cnt;  // BUSY holds
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_hgrant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      r_owner     <= DEF_IDX;
      r_hmaster   <= DEF_IDX;
      r_hmastlock <= 1'b0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_burst_cnt <= w_cnt_nxt;
      if (w_arb_en && (w_win != r_owner)) begin
        r_owner  <= w_win;
        r_hgrant <= NUM_MASTERS'(1) << w_win;
        r_rr_ptr <= w_ptr_nxt;
      end
      // Address phase follows the grant by one accepted transfer.
      if (hready) begin
        r_hmaster   <= r_owner;
        r_hmastlock <= w_lock16[r_owner];
      end
    end
  end

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter_core.sv
module tb_ahb_arbiter_core;
  import integration_pkg::*;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic [3:0] fp_gnt, rr_gnt, fp_mst, rr_mst;
  logic       fp_lck, rr_lck;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_core #(.NUM_MASTERS(4), .DEFAULT_MASTER(3), .ARB_MODE(0)) u_fp (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(fp_gnt), .hmaster(fp_mst), .hmastlock(fp_lck)
  );

  ahb_arbiter_core #(.NUM_MASTERS(4), .DEFAULT_MASTER(3), .ARB_MODE(1)) u_rr (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(rr_gnt), .hmaster(rr_mst), .hmastlock(rr_lck)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle before sampling / redriving.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    tick(2);
    hreset  = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_gnt",  32'(fp_gnt), 32'h8);
    chk("rst_mst",  32'(fp_mst), 32'd3);
    chk("rst_lck",  32'(fp_lck), 32'd0);
    tick(3);
    chk("idle_gnt", 32'(fp_gnt), 32'h8);
    chk("idle_mst", 32'(fp_mst), 32'd3);

    // Fixed priority: lowest index wins, hmaster lags one cycle
    hbusreq = 4'b0110;
    tick();
    chk("fp_gnt1", 32'(fp_gnt), 32'b0010);
    chk("fp_mst_lag", 32'(fp_mst), 32'd3);
    tick();
    chk("fp_mst1", 32'(fp_mst), 32'd1);

    // Master 2 runs INCR4; master 0 arrives at beat 2
    hbusreq = 4'b0100;
    tick();
    chk("m2_gnt", 32'(fp_gnt), 32'b0100);
    tick();
    chk("m2_mst", 32'(fp_mst), 32'd2);
    htrans = NONSEQ; hburst = INCR4;
    tick();
    chk("b1_gnt", 32'(fp_gnt), 32'b0100);
    htrans = SEQ; hbusreq = 4'b0101;
    tick();
    chk("b2_gnt", 32'(fp_gnt), 32'b0100);
    tick();
    chk("b3_gnt", 32'(fp_gnt), 32'b0100);
    tick();
    chk("b4_gnt", 32'(fp_gnt), 32'b0100);
    htrans = IDLE;
    tick();
    chk("post_burst_gnt", 32'(fp_gnt), 32'b0001);

    // Locked owner holds the bus against a higher-priority request
    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010;
    tick();
    chk("lk_gnt", 32'(fp_gnt), 32'b0010);
    tick();
    chk("lk_mst", 32'(fp_mst), 32'd1);
    chk("lk_lck", 32'(fp_lck), 32'd1);
    hbusreq = 4'b0011;
    tick(2);
    chk("lk_hold_gnt", 32'(fp_gnt), 32'b0010);
    chk("lk_hold_lck", 32'(fp_lck), 32'd1);
    hlock = 4'b0000;
    tick();
    chk("unlk_gnt", 32'(fp_gnt), 32'b0001);
    chk("unlk_lck", 32'(fp_lck), 32'd0);

    // Round-robin rotation with everyone requesting
    do_reset();
    hbusreq = 4'b1111;
    begin
      logic [3:0] rr_exp [5];
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("rr_gnt%0d", i), 32'(rr_gnt), 32'(rr_exp[i]));
      end
    end
    chk("fp_no_rot", 32'(fp_gnt), 32'b0001);

    // INCR8 stalled mid-burst, then terminated early with IDLE
    do_reset();
    hbusreq = 4'b0100;
    tick(2);
    chk("s_mst", 32'(fp_mst), 32'd2);
    htrans = NONSEQ; hburst = INCR8;
    tick();
    htrans = SEQ;
    tick();
    chk("s_cnt", 32'(u_fp.r_burst_cnt), 32'd6);
    hbusreq = 4'b0101; hready = 1'b0;
    tick(5);
    chk("stall_cnt", 32'(u_fp.r_burst_cnt), 32'd6);
    chk("stall_gnt", 32'(fp_gnt), 32'b0100);
    chk("stall_mst", 32'(fp_mst), 32'd2);
    hready = 1'b1;
    tick();
    chk("resume_cnt", 32'(u_fp.r_burst_cnt), 32'd5);
    chk("resume_gnt", 32'(fp_gnt), 32'b0100);
    htrans = IDLE;
    tick();
    chk("idle_cnt", 32'(u_fp.r_burst_cnt), 32'd0);
    chk("idle_gnt_hold", 32'(fp_gnt), 32'b0100);
    tick();
    chk("idle_rearb", 32'(fp_gnt), 32'b0001);
    tick();
    chk("idle_mst", 32'(fp_mst), 32'd0);

    // Reset mid-burst discards state
    htrans = NONSEQ; hburst = INCR16;
    tick();
    do_reset();
    chk("rst2_cnt", 32'(u_fp.r_burst_cnt), 32'd0);
    chk("rst2_gnt", 32'(fp_gnt), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
